// File: rtl/wash_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : wash_cycle_controller
// Brief    : Washing-machine sequencer (soap wash, N rinses, spin) with fill
//            and drain watchdogs, pause, door-fault detection, latched error.
// Revision : 1.0
// ============================================================================
module wash_cycle_controller #(
    parameter int CNT_W         = 8,
    parameter int WASH_TICKS    = 20,
    parameter int RINSE_TICKS   = 10,
    parameter int SPIN_TICKS    = 15,
    parameter int FILL_TIMEOUT  = 40,
    parameter int DRAIN_TIMEOUT = 40,
    parameter int NUM_RINSE     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       door_close,
    input  logic       start,
    input  logic       pause,
    input  logic       filled,
    input  logic       detergent_added,
    input  logic       drained,
    output logic       door_lock,
    output logic       motor_on,
    output logic       fill_value_on,
    output logic       drain_value_on,
    output logic       soap_wash,
    output logic       water_wash,
    output logic       done,
    output logic       error,
    output logic [2:0] rinse_idx,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_WAIT_DOOR = 4'd1,
        S_FILL      = 4'd2,
        S_DETERGENT = 4'd3,
        S_WASH      = 4'd4,
        S_DRAIN     = 4'd5,
        S_SPIN      = 4'd6,
        S_DONE      = 4'd7,
        S_ERROR     = 4'd8
    } state_t;

    localparam logic [CNT_W-1:0] c_WASH_LAST  = CNT_W'(WASH_TICKS - 1);
    localparam logic [CNT_W-1:0] c_RINSE_LAST = CNT_W'(RINSE_TICKS - 1);
    localparam logic [CNT_W-1:0] c_SPIN_LAST  = CNT_W'(SPIN_TICKS - 1);
    localparam logic [CNT_W-1:0] c_FILL_LAST  = CNT_W'(FILL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [2:0]       c_NUM_RINSE  = 3'(NUM_RINSE);

    state_t           r_state;
    logic [CNT_W-1:0] r_timer;
    logic [2:0]       r_rinse_idx;
    logic             r_start_q;

    logic             w_start_rise;
    logic             w_in_cycle;
    logic             w_agitate;
    logic             w_hold;
    logic [CNT_W-1:0] w_wash_last;

    assign w_start_rise = start & ~r_start_q;
    assign w_in_cycle   = (r_state == S_FILL) || (r_state == S_DETERGENT) ||
                          (r_state == S_WASH) || (r_state == S_DRAIN) ||
                          (r_state == S_SPIN);
    assign w_agitate    = (r_state == S_WASH) || (r_state == S_SPIN);
    assign w_hold       = w_agitate & pause;
    assign w_wash_last  = (r_rinse_idx == 3'd0) ? c_WASH_LAST : c_RINSE_LAST;

    // Timer free-runs and is zeroed by whichever branch takes a transition.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_rinse_idx <= 3'd0;
            r_start_q   <= 1'b0;
        end else begin
            r_start_q <= start;
            if (!w_hold) begin
                r_timer <= r_timer + CNT_W'(1);
            end
            if (w_in_cycle && !door_close) begin
                r_state     <= S_ERROR;
                r_timer     <= '0;
                r_rinse_idx <= 3'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start_rise) begin
                            r_state <= door_close ? S_FILL : S_WAIT_DOOR;
                            r_timer <= '0;
                        end
                    end
                    S_WAIT_DOOR: begin
                        if (door_close) begin
                            r_state <= S_FILL;
                            r_timer <= '0;
                        end
                    end
                    S_FILL: begin
                        if (filled) begin
                            r_state <= (r_rinse_idx == 3'd0) ? S_DETERGENT : S_WASH;
                            r_timer <= '0;
                        end else if (r_timer == c_FILL_LAST) begin
                            r_state     <= S_ERROR;
                            r_timer     <= '0;
                            r_rinse_idx <= 3'd0;
                        end
                    end
                    S_DETERGENT: begin
                        if (detergent_added) begin
                            r_state <= S_WASH;
                            r_timer <= '0;
                        end
                    end
                    S_WASH: begin
                        if (!pause && r_timer == w_wash_last) begin
                            r_state <= S_DRAIN;
                            r_timer <= '0;
                        end
                    end
                    S_DRAIN: begin
                        if (drained) begin
                            r_timer <= '0;
                            if (r_rinse_idx < c_NUM_RINSE) begin
                                r_rinse_idx <= r_rinse_idx + 3'd1;
                                r_state     <= S_FILL;
                            end else begin
                                r_state <= S_SPIN;
                            end
                        end else if (r_timer == c_DRAIN_LAST) begin
                            r_state     <= S_ERROR;
                            r_timer     <= '0;
                            r_rinse_idx <= 3'd0;
                        end
                    end
                    S_SPIN: begin
                        if (!pause && r_timer == c_SPIN_LAST) begin
                            r_state <= S_DONE;
                            r_timer <= '0;
                        end
                    end
                    S_DONE: begin
                        r_state     <= S_IDLE;
                        r_timer     <= '0;
                        r_rinse_idx <= 3'd0;
                    end
                    S_ERROR: begin
                        r_state <= S_ERROR;
                    end
                    default: begin
                        r_state     <= S_IDLE;
                        r_timer     <= '0;
                        r_rinse_idx <= 3'd0;
                    end
                endcase
            end
        end
    end

    assign door_lock      = w_in_cycle;
    assign motor_on       = w_agitate & ~pause;
    assign fill_value_on  = (r_state == S_FILL);
    assign drain_value_on = (r_state == S_DRAIN) || (r_state == S_SPIN) || (r_state == S_ERROR);
    assign soap_wash      = (r_state == S_WASH) && (r_rinse_idx == 3'd0);
    assign water_wash     = (r_state == S_WASH) && (r_rinse_idx != 3'd0);
    assign done           = (r_state == S_DONE);
    assign error          = (r_state == S_ERROR);
    assign rinse_idx      = r_rinse_idx;
    assign state          = r_state;

endmodule
`default_nettype wire

// File: tb/tb_wash_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_wash_cycle_controller
// Brief    : Randomized episodes against a phase-plan reference model; drives
//            a default build and a NUM_RINSE=0 build with the same stimulus.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_wash_cycle_controller;

    localparam int FILL_TO  = 40;
    localparam int DRAIN_TO = 40;
    localparam int WASH_T   = 20;
    localparam int RINSE_T  = 10;
    localparam int SPIN_T   = 15;
    localparam int EPISODES = 40;
    localparam int EP_LEN   = 260;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic door_close = 1'b0, start = 1'b0, pause = 1'b0;
    logic filled = 1'b0, detergent_added = 1'b0, drained = 1'b0;

    logic [1:0] door_lock, motor_on, fill_value_on, drain_value_on;
    logic [1:0] soap_wash, water_wash, done, error;
    logic [2:0] rinse_idx [2];
    logic [3:0] state     [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Model: mode 0 idle, 1 waiting for door, 2 running through plan, 3 error.
    int   m_mode [2];
    int   m_pos  [2];
    int   m_el   [2];
    logic m_sq;
    int   plan_code [2][32];
    int   plan_rin  [2][32];

    int fill_mode, drain_mode, door_mode, pause_en, hold_start, door_delay, rst_at;

    always #5 clk = ~clk;

    wash_cycle_controller u_dut0 (
        .clk(clk), .reset(reset), .door_close(door_close), .start(start), .pause(pause),
        .filled(filled), .detergent_added(detergent_added), .drained(drained),
        .door_lock(door_lock[0]), .motor_on(motor_on[0]), .fill_value_on(fill_value_on[0]),
        .drain_value_on(drain_value_on[0]), .soap_wash(soap_wash[0]), .water_wash(water_wash[0]),
        .done(done[0]), .error(error[0]), .rinse_idx(rinse_idx[0]), .state(state[0])
    );

    wash_cycle_controller #(.NUM_RINSE(0)) u_dut1 (
        .clk(clk), .reset(reset), .door_close(door_close), .start(start), .pause(pause),
        .filled(filled), .detergent_added(detergent_added), .drained(drained),
        .door_lock(door_lock[1]), .motor_on(motor_on[1]), .fill_value_on(fill_value_on[1]),
        .drain_value_on(drain_value_on[1]), .soap_wash(soap_wash[1]), .water_wash(water_wash[1]),
        .done(done[1]), .error(error[1]), .rinse_idx(rinse_idx[1]), .state(state[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic build_plan(input int k, input int n);
        int p;
        p = 0;
        plan_code[k][p] = 2; plan_rin[k][p] = 0; p++;
        plan_code[k][p] = 3; plan_rin[k][p] = 0; p++;
        plan_code[k][p] = 4; plan_rin[k][p] = 0; p++;
        plan_code[k][p] = 5; plan_rin[k][p] = 0; p++;
        for (int r = 1; r <= n; r++) begin
            plan_code[k][p] = 2; plan_rin[k][p] = r; p++;
            plan_code[k][p] = 4; plan_rin[k][p] = r; p++;
            plan_code[k][p] = 5; plan_rin[k][p] = r; p++;
        end
        plan_code[k][p] = 6; plan_rin[k][p] = n; p++;
        plan_code[k][p] = 7; plan_rin[k][p] = n;
    endtask

    function automatic int exp_code(input int k);
        case (m_mode[k])
            0:       return 0;
            1:       return 1;
            2:       return plan_code[k][m_pos[k]];
            default: return 8;
        endcase
    endfunction

    function automatic int exp_rin(input int k);
        return (m_mode[k] == 2) ? plan_rin[k][m_pos[k]] : 0;
    endfunction

    function automatic logic [7:0] exp_out(input int k);
        int c, r;
        c = exp_code(k);
        r = exp_rin(k);
        return {(c >= 2 && c <= 6), ((c == 4 || c == 6) && !pause), (c == 2),
                (c == 5 || c == 6 || c == 8), (c == 4 && r == 0), (c == 4 && r != 0),
                (c == 7), (c == 8)};
    endfunction

    task automatic advance(input int k);
        m_pos[k]++;
        m_el[k] = 0;
    endtask

    task automatic model_step(input int k);
        int c, t;
        c = exp_code(k);
        if (c >= 2 && c <= 6 && !door_close) begin
            m_mode[k] = 3;
            return;
        end
        case (m_mode[k])
            0: if (start && !m_sq) begin
                   m_mode[k] = door_close ? 2 : 1;
                   m_pos[k]  = 0;
                   m_el[k]   = 0;
               end
            1: if (door_close) begin
                   m_mode[k] = 2;
                   m_pos[k]  = 0;
                   m_el[k]   = 0;
               end
            2: begin
                case (c)
                    2: if (filled) advance(k);
                       else if (m_el[k] == FILL_TO - 1) m_mode[k] = 3;
                       else m_el[k]++;
                    3: if (detergent_added) advance(k);
                       else m_el[k]++;
                    4, 6: if (!pause) begin
                        t = (c == 6) ? SPIN_T : ((plan_rin[k][m_pos[k]] == 0) ? WASH_T : RINSE_T);
                        if (m_el[k] + 1 >= t) advance(k);
                        else m_el[k]++;
                    end
                    5: if (drained) advance(k);
                       else if (m_el[k] == DRAIN_TO - 1) m_mode[k] = 3;
                       else m_el[k]++;
                    default: m_mode[k] = 0;
                endcase
            end
            default: ;
        endcase
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                m_mode[k] = 0;
                m_pos[k]  = 0;
                m_el[k]   = 0;
            end
            m_sq = 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) model_step(k);
            m_sq = start;
        end
    end

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("state[%0d]", k), 32'(state[k]), 32'(exp_code(k)));
            if (m_mode[k] != 3)
                check_eq($sformatf("rinse_idx[%0d]", k), 32'(rinse_idx[k]), 32'(exp_rin(k)));
            check_eq($sformatf("outs[%0d]", k),
                     32'({door_lock[k], motor_on[k], fill_value_on[k], drain_value_on[k],
                          soap_wash[k], water_wash[k], done[k], error[k]}),
                     32'(exp_out(k)));
        end
    endtask

    function automatic logic at_boundary(input int code, input int limit);
        return (m_mode[0] == 2) && (plan_code[0][m_pos[0]] == code) && (m_el[0] == limit - 1);
    endfunction

    task automatic drive_inputs(input int cyc);
        door_close = (cyc < door_delay) ? 1'b0 :
                     (door_mode != 0) ? ($urandom_range(0, 79) != 0) : 1'b1;
        start = (hold_start != 0) ? (cyc >= 1) : ((cyc == 1) || ($urandom_range(0, 31) == 0));
        pause = (pause_en != 0) && ($urandom_range(0, 5) == 0);
        filled = (fill_mode == 0) ? 1'b0 :
                 (fill_mode == 2) ? at_boundary(2, FILL_TO) : ($urandom_range(0, 3) == 0);
        drained = (drain_mode == 0) ? 1'b0 :
                  (drain_mode == 2) ? at_boundary(5, DRAIN_TO) : ($urandom_range(0, 3) == 0);
        detergent_added = ($urandom_range(0, 2) == 0);
    endtask

    initial begin
        build_plan(0, 2);
        build_plan(1, 0);
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        compare_all();
        for (int ep = 0; ep < EPISODES; ep++) begin
            fill_mode  = ($urandom_range(0, 7) == 0) ? 0 : (($urandom_range(0, 3) == 0) ? 2 : 1);
            drain_mode = ($urandom_range(0, 7) == 0) ? 0 : (($urandom_range(0, 3) == 0) ? 2 : 1);
            door_mode  = ($urandom_range(0, 4) == 0) ? 1 : 0;
            pause_en   = $urandom_range(0, 1);
            hold_start = ($urandom_range(0, 3) == 0) ? 1 : 0;
            door_delay = $urandom_range(0, 6);
            rst_at     = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 200) : -1;
            @(negedge clk);
            reset = 1'b0;
            start = 1'b0;
            pause = 1'b0;
            #1;
            compare_all();
            for (int cyc = 0; cyc < EP_LEN; cyc++) begin
                @(negedge clk);
                compare_all();
                if (!reset) begin
                    reset = 1'b1;
                end else if (cyc == rst_at) begin
                    reset = 1'b0;
                    #1;
                    compare_all();
                end
                drive_inputs(cyc);
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
